vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The module SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The module SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The module SHALL have parameter V_BP, default 29, vertical back porch in lines.
REQ-009 The module SHALL have parameter CLK_DIV, default 2, clk_50 cycles per pixel; legal range 1..16.
REQ-010 The module SHALL have parameter HS_POL, default 0, the active level of HS.
REQ-011 The module SHALL have parameter VS_POL, default 0, the active level of VS.
REQ-012 The module SHALL have parameter CW, default 10, width of row and col.
REQ-013 The module SHALL have port clk_50, input, 1 bit, the only clock.
REQ-014 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-015 The module SHALL have port en, input, 1 bit; when high, timing advances.
REQ-016 The module SHALL have port col, output, CW bits, current pixel column (h_cnt).
REQ-017 The module SHALL have port row, output, CW bits, current line (v_cnt).
REQ-018 The module SHALL have ports HS and VS, outputs, 1 bit each, the sync signals.
REQ-019 The module SHALL have port blank, output, 1 bit, high outside the active area.
REQ-020 The module SHALL have port pix_en, output, 1 bit, pixel strobe.
REQ-021 The module SHALL have ports line_start and frame_start, outputs, 1 bit each, single-clock pulses.
REQ-022 The module SHALL have port frame_count, output, 16 bits, number of completed frames.

Function
REQ-023 The module SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-024 The module SHALL hold an internal divider div_cnt; when en=1, div_cnt increments and wraps from CLK_DIV-1 to 0.
REQ-025 pix_en SHALL be 1 exactly when en=1 and div_cnt==CLK_DIV-1; when CLK_DIV=1, pix_en SHALL equal en.
REQ-026 On pix_en, h_cnt SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-027 On pix_en with h_cnt==H_TOTAL-1, v_cnt SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-028 On pix_en with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1, frame_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-029 When en=0, all counters SHALL hold and pix_en, line_start and frame_start SHALL be 0; when en returns to 1, counting SHALL resume from the held values.
REQ-030 HS SHALL equal HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-031 VS SHALL equal VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise.
REQ-032 blank SHALL be 1 when h_cnt >= H_ACTIVE or v_cnt >= V_ACTIVE.
REQ-033 HS, VS and blank SHALL be flop outputs updated in the same edge as the counters, so they are always consistent with the col/row of the same cycle (zero relative skew, glitch-free).
REQ-034 line_start SHALL be 1 for one clk_50 cycle when en=1, div_cnt==0 and h_cnt==0.
REQ-035 frame_start SHALL be 1 for one clk_50 cycle when en=1, div_cnt==0, h_cnt==0 and v_cnt==0.
REQ-036 col and row SHALL equal h_cnt and v_cnt; counters SHALL be wide enough for H_TOTAL-1 and V_TOTAL-1, and truncation to CW bits is legal only if H_TOTAL, V_TOTAL <= 2^CW.

Reset
REQ-037 While reset=1 at a clk_50 edge, the following SHALL be cleared to 0, overriding en: div_cnt, h_cnt, v_cnt and frame_count.
REQ-038 While reset=1, outputs SHALL be: HS=~HS_POL, VS=~VS_POL, blank=0, pix_en=0, line_start=0, frame_start=0.
REQ-039 An assertion of reset mid-frame SHALL restart timing at (0,0) in the next cycle, with no partial sync pulse held over.
REQ-040 In the first cycle after reset deasserts with en=1, line_start and frame_start SHALL both be 1.

Verification
REQ-041 Defaults with en=1 -> HS low for 192 clk per line at col 656..751; line period 1600 clk; frame period 833600 clk; VS low on rows 490..491.
REQ-042 Parameters H=4/1/1/2, V=3/1/1/1, CLK_DIV=1 -> col runs 0..7; HS low at col 5; blank=1 for col>=4 or row>=3; frame_start every 48 clk.
REQ-043 Drop en for 37 cycles at col=100 -> col, row and div_cnt are frozen and all pulses are 0; after en=1, col reaches 101 after the remaining divider cycles.
REQ-044 Assert reset at row 300, col 700 -> the next cycle shows row=0, col=0 and inactive syncs; frame_count=0.
REQ-045 HS_POL=1, VS_POL=1 -> the sync levels are inverted relative to REQ-041 and all timing is identical.
REQ-046 Run 65537 frames on the small configuration -> frame_count wraps to 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the VGA timing generator (master) and the video
// pipeline that consumes the raster position, syncs and strobes (slave).
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          HS;
    logic          VS;
    logic          blank;
    logic          pix_en;
    logic          line_start;
    logic          frame_start;
    logic [15:0]   frame_count;

    modport master (
        input  en,
        output col, row, HS, VS, blank, pix_en, line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  col, row, HS, VS, blank, pix_en, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clk_50 down to a pixel strobe, walks the h/v raster
// and registers sync/blank on the same edge as the counters so they never skew.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic             clk_50,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic          pix_en;
    logic          line_start;
    logic          frame_start;
    logic          h_last;
    logic          v_last;

    // Strobes are decoded from the current state so they drop the same cycle en or reset does.
    assign pix_en      = ~reset & vga.en & (div_q == DIV_LAST);
    assign line_start  = ~reset & vga.en & (div_q == '0) & (h_q == '0);
    assign frame_start = line_start & (v_q == '0);
    assign h_last      = (h_q == H_LAST);
    assign v_last      = (v_q == V_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        frame_count_d = frame_count_q;

        if (vga.en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (pix_en) begin
            h_d = h_last ? '0 : h_q + HW'(1);
            if (h_last) begin
                v_d = v_last ? '0 : v_q + VW'(1);
                if (v_last) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
        end
    end

    // Sync and blank are decoded from the next counter values, then registered alongside them.
    always_comb begin
        hs_d    = (int'(h_d) >= HS_START && int'(h_d) < HS_END) ? HS_POL : ~HS_POL;
        vs_d    = (int'(v_d) >= VS_START && int'(v_d) < VS_END) ? VS_POL : ~VS_POL;
        blank_d = (int'(h_d) >= H_ACTIVE) || (int'(v_d) >= V_ACTIVE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_count_q <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_count_q <= frame_count_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
        end
    end

    assign vga.col         = CW'(h_q);
    assign vga.row         = CW'(v_q);
    assign vga.HS          = hs_q;
    assign vga.VS          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.pix_en      = pix_en;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_count_q;
endmodule
